it_sequencer: RTL and testbench

Interrupt and halt sequencer that drives the PC unit's override controls: do_halt_pc, do_interrupt/interrupt_pc and do_it_load_pc/it_return_pc.
- Arbitrates among NUM_IRQ level-sensitive requesters using fixed priority.
- Drains the pipeline, redirects fetch to a vector, and records the return address.
- Restores the return address on IRET.
- Implements WFI (wait-for-interrupt) halting.
- Sits beside the PC unit and updates on the same negedge clock as the PC register.

---
 rtl/it_sequencer_pkg.sv | 24 ++
 rtl/it_sequencer_prio.sv | 22 ++
 rtl/it_sequencer.sv | 139 +++++++++++++
 tb/tb_it_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/it_sequencer_pkg.sv
// Shared definitions for the interrupt/halt sequencer: state encoding,
// default vector layout and the vector address helper.
package it_sequencer_pkg;

    typedef enum logic [2:0] {
        IT_IDLE    = 3'd0,
        IT_HALT    = 3'd1,
        IT_DRAIN   = 3'd2,
        IT_ENTER   = 3'd3,
        IT_SERVICE = 3'd4,
        IT_RETURN  = 3'd5
    } it_state_e;

    localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0010;
    localparam int unsigned DEF_VECTOR_STRIDE = 8;

    // Vector address for a cause index; wraps at 32 bits.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [2:0]  cause);
        return base + ({29'b0, cause} * stride);
    endfunction

endpackage

// File: rtl/it_sequencer_prio.sv
// Fixed-priority encoder: bit 0 wins, reports valid and index of lowest set bit.
module it_prio_enc #(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [2:0]         idx_o
);

    // Scan upward and keep the first set bit found.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req_i[i] && !valid_o) begin
                valid_o = 1'b1;
                idx_o   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/it_sequencer.sv
// Interrupt and halt sequencer driving the PC unit override controls.
// State advances on the falling clock edge, alongside the PC register.
module it_sequencer
    import it_sequencer_pkg::*;
#(
    parameter int unsigned NUM_IRQ       = 4,
    parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
    parameter int unsigned VECTOR_STRIDE = DEF_VECTOR_STRIDE,
    parameter int unsigned DRAIN_CYCLES  = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               it_enable,
    input  logic [31:0]        current_pc,
    input  logic               do_flush_REG1,
    input  logic               do_hazard,
    input  logic               do_iret,
    input  logic               do_wfi,
    output logic               do_halt_pc,
    output logic               do_interrupt,
    output logic [31:0]        interrupt_pc,
    output logic               do_it_load_pc,
    output logic [31:0]        it_return_pc,
    output logic [NUM_IRQ-1:0] it_ack,
    output logic               it_active,
    output logic [2:0]         it_cause
);

    localparam logic [2:0]         DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
    localparam logic [NUM_IRQ-1:0] ACK_LSB    = NUM_IRQ'(1);

    it_state_e          state_q;
    logic [2:0]         cnt_q;
    logic               halt_q;
    logic               intr_q;
    logic               load_q;
    logic               active_q;
    logic [31:0]        ipc_q;
    logic [31:0]        rpc_q;
    logic [NUM_IRQ-1:0] ack_q;
    logic [2:0]         cause_q;

    logic               win_valid;
    logic [2:0]         win_idx;
    logic               pending;

    it_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req_i   (irq),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    assign pending = it_enable && win_valid;

    // Sequencer FSM; every output is a register set on entry to its state.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IT_IDLE;
            cnt_q    <= '0;
            halt_q   <= 1'b0;
            intr_q   <= 1'b0;
            load_q   <= 1'b0;
            active_q <= 1'b0;
            ipc_q    <= '0;
            rpc_q    <= '0;
            ack_q    <= '0;
            cause_q  <= '0;
        end else begin
            intr_q <= 1'b0;
            load_q <= 1'b0;
            ack_q  <= '0;
            case (state_q)
                IT_IDLE: begin
                    if (pending && !do_flush_REG1 && !do_hazard) begin
                        state_q <= IT_DRAIN;
                        cnt_q   <= DRAIN_LOAD;
                        cause_q <= win_idx;
                        ipc_q   <= vec_addr(VECTOR_BASE, VECTOR_STRIDE, win_idx);
                        halt_q  <= 1'b1;
                    end else if (do_wfi) begin
                        state_q <= IT_HALT;
                        halt_q  <= 1'b1;
                    end
                end
                IT_HALT: begin
                    if (pending) begin
                        state_q <= IT_DRAIN;
                        cnt_q   <= DRAIN_LOAD;
                        cause_q <= win_idx;
                        ipc_q   <= vec_addr(VECTOR_BASE, VECTOR_STRIDE, win_idx);
                    end
                end
                IT_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= IT_ENTER;
                        rpc_q   <= current_pc;
                        halt_q  <= 1'b0;
                        intr_q  <= 1'b1;
                        ack_q   <= ACK_LSB << cause_q;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                IT_ENTER: begin
                    state_q  <= IT_SERVICE;
                    active_q <= 1'b1;
                end
                IT_SERVICE: begin
                    if (do_iret) begin
                        state_q <= IT_RETURN;
                        load_q  <= 1'b1;
                    end
                end
                IT_RETURN: begin
                    state_q  <= IT_IDLE;
                    active_q <= 1'b0;
                end
                default: begin
                    state_q  <= IT_IDLE;
                    halt_q   <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign do_halt_pc    = halt_q;
    assign do_interrupt  = intr_q;
    assign interrupt_pc  = ipc_q;
    assign do_it_load_pc = load_q;
    assign it_return_pc  = rpc_q;
    assign it_ack        = ack_q;
    assign it_active     = active_q;
    assign it_cause      = cause_q;

endmodule

// File: tb/tb_it_sequencer.sv
// Directed bench for it_sequencer: vector table plus hand-written sequences.
module tb_it_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        it_enable;
    logic [31:0] current_pc;
    logic        do_flush_REG1;
    logic        do_hazard;
    logic        do_iret;
    logic        do_wfi;
    logic        do_halt_pc;
    logic        do_interrupt;
    logic [31:0] interrupt_pc;
    logic        do_it_load_pc;
    logic [31:0] it_return_pc;
    logic [3:0]  it_ack;
    logic        it_active;
    logic [2:0]  it_cause;

    int checks = 0;
    int errors = 0;

    it_sequencer #(
        .NUM_IRQ       (4),
        .VECTOR_BASE   (32'h0000_0010),
        .VECTOR_STRIDE (8),
        .DRAIN_CYCLES  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .irq           (irq),
        .it_enable     (it_enable),
        .current_pc    (current_pc),
        .do_flush_REG1 (do_flush_REG1),
        .do_hazard     (do_hazard),
        .do_iret       (do_iret),
        .do_wfi        (do_wfi),
        .do_halt_pc    (do_halt_pc),
        .do_interrupt  (do_interrupt),
        .interrupt_pc  (interrupt_pc),
        .do_it_load_pc (do_it_load_pc),
        .it_return_pc  (it_return_pc),
        .it_ack        (it_ack),
        .it_active     (it_active),
        .it_cause      (it_cause)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  irq;
        logic        iret;
        logic [31:0] pc;
        logic        halt;
        logic        intr;
        logic        load;
        logic [31:0] ipc;
        logic [31:0] rpc;
        logic [3:0]  ack;
        logic        active;
        logic [2:0]  cause;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic halt, input logic intr,
                           input logic load, input logic [31:0] ipc,
                           input logic [31:0] rpc, input logic [3:0] ack,
                           input logic active, input logic [2:0] cause);
        chk({tag, ".halt"},   32'(do_halt_pc),    32'(halt));
        chk({tag, ".intr"},   32'(do_interrupt),  32'(intr));
        chk({tag, ".load"},   32'(do_it_load_pc), 32'(load));
        chk({tag, ".ipc"},    interrupt_pc,       ipc);
        chk({tag, ".rpc"},    it_return_pc,       rpc);
        chk({tag, ".ack"},    32'(it_ack),        32'(ack));
        chk({tag, ".active"}, 32'(it_active),     32'(active));
        chk({tag, ".cause"},  32'(it_cause),      32'(cause));
    endtask

    // DUT updates on the falling edge; outputs are sampled on the rising edge.
    task automatic tick();
        @(negedge clock);
        @(posedge clock);
    endtask

    // Entry blocked by flush or hazard, then taken once the gate drops.
    task automatic gated_entry(input bit use_hazard, input string tag);
        irq = 4'b0100;
        if (use_hazard) do_hazard = 1'b1; else do_flush_REG1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, ".blocked_halt"}, 32'(do_halt_pc), 32'd0);
            chk({tag, ".blocked_intr"}, 32'(do_interrupt), 32'd0);
        end
        do_hazard     = 1'b0;
        do_flush_REG1 = 1'b0;
        tick();
        chk({tag, ".drain_halt"}, 32'(do_halt_pc), 32'd1);
        chk({tag, ".drain_cause"}, 32'(it_cause), 32'd2);
        chk({tag, ".drain_ipc"}, interrupt_pc, 32'h20);
        tick();
        chk({tag, ".drain2_halt"}, 32'(do_halt_pc), 32'd1);
        tick();
        chk({tag, ".enter_intr"}, 32'(do_interrupt), 32'd1);
        chk({tag, ".enter_ack"}, 32'(it_ack), 32'b0100);
        irq = 4'b0000;
        tick();
        chk({tag, ".svc_active"}, 32'(it_active), 32'd1);
        do_iret = 1'b1;
        tick();
        chk({tag, ".ret_load"}, 32'(do_it_load_pc), 32'd1);
        do_iret = 1'b0;
        tick();
        chk({tag, ".idle_active"}, 32'(it_active), 32'd0);
    endtask

    initial begin
        //           irq      iret  pc        halt  intr  load  ipc       rpc       ack      act   cause
        vecs[0]  = '{4'b0100, 1'b0, 32'h100,  1'b1, 1'b0, 1'b0, 32'h20,  32'h000,  4'b0000, 1'b0, 3'd2};
        vecs[1]  = '{4'b0100, 1'b0, 32'h100,  1'b1, 1'b0, 1'b0, 32'h20,  32'h000,  4'b0000, 1'b0, 3'd2};
        vecs[2]  = '{4'b0100, 1'b0, 32'h100,  1'b0, 1'b1, 1'b0, 32'h20,  32'h100,  4'b0100, 1'b0, 3'd2};
        vecs[3]  = '{4'b0000, 1'b0, 32'h100,  1'b0, 1'b0, 1'b0, 32'h20,  32'h100,  4'b0000, 1'b1, 3'd2};
        vecs[4]  = '{4'b0001, 1'b0, 32'h100,  1'b0, 1'b0, 1'b0, 32'h20,  32'h100,  4'b0000, 1'b1, 3'd2};
        vecs[5]  = '{4'b0001, 1'b1, 32'h100,  1'b0, 1'b0, 1'b1, 32'h20,  32'h100,  4'b0000, 1'b1, 3'd2};
        vecs[6]  = '{4'b0001, 1'b0, 32'h100,  1'b0, 1'b0, 1'b0, 32'h20,  32'h100,  4'b0000, 1'b0, 3'd2};
        vecs[7]  = '{4'b0001, 1'b0, 32'h100,  1'b1, 1'b0, 1'b0, 32'h10,  32'h100,  4'b0000, 1'b0, 3'd0};
        vecs[8]  = '{4'b0001, 1'b0, 32'h100,  1'b1, 1'b0, 1'b0, 32'h10,  32'h100,  4'b0000, 1'b0, 3'd0};
        vecs[9]  = '{4'b0001, 1'b0, 32'h200,  1'b0, 1'b1, 1'b0, 32'h10,  32'h200,  4'b0001, 1'b0, 3'd0};
        vecs[10] = '{4'b0000, 1'b0, 32'h200,  1'b0, 1'b0, 1'b0, 32'h10,  32'h200,  4'b0000, 1'b1, 3'd0};
        vecs[11] = '{4'b0000, 1'b1, 32'h200,  1'b0, 1'b0, 1'b1, 32'h10,  32'h200,  4'b0000, 1'b1, 3'd0};
        vecs[12] = '{4'b1010, 1'b0, 32'h200,  1'b0, 1'b0, 1'b0, 32'h10,  32'h200,  4'b0000, 1'b0, 3'd0};
        vecs[13] = '{4'b1010, 1'b0, 32'h200,  1'b1, 1'b0, 1'b0, 32'h18,  32'h200,  4'b0000, 1'b0, 3'd1};
        vecs[14] = '{4'b1010, 1'b0, 32'h200,  1'b1, 1'b0, 1'b0, 32'h18,  32'h200,  4'b0000, 1'b0, 3'd1};
        vecs[15] = '{4'b0000, 1'b0, 32'h200,  1'b0, 1'b1, 1'b0, 32'h18,  32'h200,  4'b0010, 1'b0, 3'd1};
        vecs[16] = '{4'b0000, 1'b0, 32'h200,  1'b0, 1'b0, 1'b0, 32'h18,  32'h200,  4'b0000, 1'b1, 3'd1};
        vecs[17] = '{4'b0000, 1'b1, 32'h200,  1'b0, 1'b0, 1'b1, 32'h18,  32'h200,  4'b0000, 1'b1, 3'd1};
        vecs[18] = '{4'b0000, 1'b0, 32'h200,  1'b0, 1'b0, 1'b0, 32'h18,  32'h200,  4'b0000, 1'b0, 3'd1};

        reset         = 1'b1;
        irq           = '0;
        it_enable     = 1'b1;
        current_pc    = 32'h100;
        do_flush_REG1 = 1'b0;
        do_hazard     = 1'b0;
        do_iret       = 1'b0;
        do_wfi        = 1'b0;
        #2;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 3'd0);
        @(posedge clock);
        reset = 1'b0;

        // Entry, no nesting, return, re-entry, priority and drain immunity.
        for (int i = 0; i < 19; i++) begin
            irq        = vecs[i].irq;
            do_iret    = vecs[i].iret;
            current_pc = vecs[i].pc;
            tick();
            chk_all($sformatf("v%0d", i), vecs[i].halt, vecs[i].intr, vecs[i].load,
                    vecs[i].ipc, vecs[i].rpc, vecs[i].ack, vecs[i].active, vecs[i].cause);
        end
        do_iret = 1'b0;

        gated_entry(1'b0, "flush");
        gated_entry(1'b1, "hazard");

        // WFI halt; a masked irq must not wake it.
        irq    = '0;
        do_wfi = 1'b1;
        tick();
        chk("wfi.halt", 32'(do_halt_pc), 32'd1);
        do_wfi = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i == 5) begin
                irq       = 4'b1000;
                it_enable = 1'b0;
            end
            tick();
            chk($sformatf("wfi.hold%0d", i), 32'(do_halt_pc), 32'd1);
            chk($sformatf("wfi.nointr%0d", i), 32'(do_interrupt), 32'd0);
        end
        it_enable = 1'b1;
        tick();
        chk("wfi.drain_halt", 32'(do_halt_pc), 32'd1);
        chk("wfi.cause", 32'(it_cause), 32'd3);
        chk("wfi.ipc", interrupt_pc, 32'h28);
        tick();
        chk("wfi.drain2_halt", 32'(do_halt_pc), 32'd1);
        tick();
        chk_all("wfi.enter", 1'b0, 1'b1, 1'b0, 32'h28, 32'h200, 4'b1000, 1'b0, 3'd3);
        irq = '0;
        tick();
        do_iret = 1'b1;
        tick();
        do_iret = 1'b0;
        tick();
        chk("wfi.idle_active", 32'(it_active), 32'd0);

        // Asynchronous reset between edges while draining.
        irq = 4'b0001;
        tick();
        chk("rst.drain_halt", 32'(do_halt_pc), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all("rst.async", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 3'd0);
        @(negedge clock);
        #1;
        chk("rst.held_intr", 32'(do_interrupt), 32'd0);
        @(posedge clock);
        reset = 1'b0;
        irq   = '0;
        tick();
        chk_all("rst.idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 3'd0);
        irq = 4'b0001;
        tick();
        chk("rst.reentry_halt", 32'(do_halt_pc), 32'd1);
        chk("rst.reentry_ipc", interrupt_pc, 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
